// File: rtl/mul_pkg.sv
// ============================================================================
// mul_pkg : shared types and sizing helpers for the multiply/accumulate path
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mul_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_COUNT = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Sum width leaves room for COUNT full-scale cubes, so the adder never wraps.
  function automatic int sum_width(input int width, input int count);
    return 3 * width + $clog2(count);
  endfunction

  function automatic int cnt_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/product_accum_if.sv
// ============================================================================
// product_accum_if : product-in / frame-sum-out handshake bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface product_accum_if
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int COUNT = DEF_COUNT
);

  localparam int SUM_W = sum_width(WIDTH, COUNT);
  localparam int CNT_W = cnt_width(COUNT);

  logic               in_valid;
  logic               in_ready;
  logic [3*WIDTH-1:0] in_mul;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [SUM_W-1:0]   out_sum;
  logic [CNT_W-1:0]   out_count;

  modport master (
    output in_valid, in_mul, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_mul, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );

endinterface

`default_nettype wire

// File: rtl/product_accum.sv
// ============================================================================
// product_accum : sums COUNT upstream products per frame, presents the result
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module product_accum
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int COUNT = DEF_COUNT
) (
  input  wire logic        clk,
  input  wire logic        rst,
  product_accum_if.slave   bus
);

  localparam int SUM_W = sum_width(WIDTH, COUNT);
  localparam int CNT_W = cnt_width(COUNT);
  localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

  generate
    if (COUNT < 1 || COUNT > 255) begin : g_bad_count
      $error("product_accum: COUNT out of range 1..255");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_ready;
  logic             accept;
  logic [SUM_W-1:0] mul_ext;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = !rst && (state_q != HOLD);
  assign accept   = bus.in_valid && in_ready;
  assign mul_ext  = SUM_W'(bus.in_mul);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = mul_ext;
          cnt_d   = CNT_W'(1);
          state_d = (COUNT == 1 || bus.flush) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = acc_q + mul_ext;
          cnt_d   = cnt_inc;
          // A flushed beat is still summed before the frame closes.
          if (cnt_inc == COUNT_C || bus.flush) begin
            state_d = HOLD;
          end
        end else if (bus.flush) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result fields are forced to zero outside HOLD so partial sums never leak.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = (state_q == HOLD);
    bus.out_sum   = (state_q == HOLD) ? acc_q : '0;
    bus.out_count = (state_q == HOLD) ? cnt_q : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_product_accum.sv
// ============================================================================
// tb_product_accum : directed and random checks against a frame-level model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_product_accum;

  localparam int WIDTH = 4;
  localparam int COUNT = 5;

  logic clk;
  logic rst;

  product_accum_if #(.WIDTH(WIDTH), .COUNT(COUNT)) bus ();

  product_accum #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: terms of the open frame, and whether that frame is being presented.
  int q[$];
  bit holding = 1'b0;

  function automatic int model_sum();
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs(input bit r);
    check("in_ready",  32'(bus.in_ready),  32'(!r && !holding));
    check("out_valid", 32'(bus.out_valid), 32'(holding));
    check("out_sum",   32'(bus.out_sum),   holding ? 32'(model_sum()) : 32'd0);
    check("out_count", 32'(bus.out_count), holding ? 32'(q.size()) : 32'd0);
  endtask

  task automatic model_step(input bit r, input bit v, input int m, input bit f, input bit o);
    if (r) begin
      q.delete();
      holding = 1'b0;
    end else if (holding) begin
      if (o) begin
        q.delete();
        holding = 1'b0;
      end
    end else if (v) begin
      q.push_back(m);
      if (q.size() == COUNT || f) holding = 1'b1;
    end else if (f && q.size() > 0) begin
      holding = 1'b1;
    end
  endtask

  // One clock: drive at the falling edge, compare, then advance the model.
  task automatic cycle(input bit r, input bit v, input int m, input bit f, input bit o);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.in_mul    = 12'(m);
    bus.flush     = f;
    bus.out_ready = o;
    #1;
    compare_outputs(r);
    model_step(r, v, m, f, o);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mul    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 5, 1, 1);
    cycle(0, 0, 0, 0, 0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_sum",   32'(bus.out_sum),   32'd0);

    // 1..5 back-to-back, then result held three cycles with in_valid high
    for (int i = 1; i <= 5; i++) cycle(0, 1, i, 0, 0);
    cycle(0, 1, 99, 0, 0);
    check("seq_valid", 32'(bus.out_valid), 32'd1);
    check("seq_sum",   32'(bus.out_sum),   32'd15);
    check("seq_count", 32'(bus.out_count), 32'd5);
    check("hold_ready", 32'(bus.in_ready), 32'd0);
    cycle(0, 1, 99, 0, 0);
    cycle(0, 1, 99, 0, 0);
    check("hold_sum", 32'(bus.out_sum), 32'd15);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    check("after_hs_valid", 32'(bus.out_valid), 32'd0);

    // Full-scale products
    for (int i = 0; i < 5; i++) cycle(0, 1, 'hD2F, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check("max_sum",   32'(bus.out_sum),   32'h41EB);
    check("max_count", 32'(bus.out_count), 32'd5);

    // Early flush on the second beat
    cycle(0, 1, 7, 0, 0);
    cycle(0, 1, 9, 1, 0);
    cycle(0, 0, 0, 0, 1);
    check("flush_sum",   32'(bus.out_sum),   32'd16);
    check("flush_count", 32'(bus.out_count), 32'd2);

    // Reset mid-frame discards the partial sum
    for (int i = 0; i < 3; i++) cycle(0, 1, 3, 0, 1);
    cycle(1, 1, 3, 0, 1);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check("postrst_sum",   32'(bus.out_sum),   32'd5);
    check("postrst_count", 32'(bus.out_count), 32'd5);

    // Flush with nothing buffered is ignored
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1);
    check("idle_flush_valid", 32'(bus.out_valid), 32'd0);
    check("idle_flush_ready", 32'(bus.in_ready),  32'd1);

    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(99) < 2),
            ($urandom_range(99) < 70),
            int'($urandom_range(4095)),
            ($urandom_range(99) < 10),
            ($urandom_range(99) < 50));
    end
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/product_accum.md
PRODUCT_ACCUM -- requirements
Module: product_accum

Interface
REQ-001 Parameter WIDTH, default 4: operand width of the upstream multiplicacion stage.
REQ-002 Parameter COUNT, default 5: number of products summed per frame; legal range 1..255.
REQ-003 Derived constant SUM_W = 3*WIDTH + $clog2(COUNT); CNT_W = $clog2(COUNT+1).
REQ-004 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  upstream product present.
REQ-008 in_ready  out  1  block can accept a product this cycle.
REQ-009 in_mul  in  3*WIDTH  unsigned product from multiplicacion (mul port).
REQ-010 flush  in  1  close the current frame early.
REQ-011 out_valid  out  1  frame result available.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 out_sum  out  SUM_W  unsigned sum of the frame's products.
REQ-014 out_count  out  CNT_W  number of products in out_sum.

Function
REQ-015 FSM states: IDLE (empty), ACCUM (1..COUNT-1 terms held), HOLD (result presented).
REQ-016 Accept = in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD and while rst is high.
REQ-017 IDLE accept: acc <= zero-extended in_mul, cnt <= 1; next state ACCUM, or HOLD if COUNT==1.
REQ-018 ACCUM accept: acc <= acc + in_mul, cnt <= cnt+1; when the new cnt equals COUNT, next state HOLD.
REQ-019 Latency: out_valid SHALL rise on the cycle after the accept that completes the frame; back-to-back accepts at one per cycle are supported.
REQ-020 flush in ACCUM without accept: next state HOLD with current acc/cnt.
REQ-021 flush in ACCUM with accept: the beat is summed, then HOLD.
REQ-022 flush in IDLE with accept: the single beat forms a frame (HOLD, count 1); flush in IDLE without accept, or in HOLD, SHALL be ignored.
REQ-023 HOLD: out_valid=1, out_sum=acc, out_count=cnt, all stable until out_valid && out_ready.
REQ-024 Result handshake: next state IDLE, acc and cnt cleared; no new beat accepted in that same cycle.
REQ-025 out_valid, out_sum, out_count SHALL be 0 in IDLE and ACCUM.
REQ-026 SUM_W guarantees no overflow: COUNT*(2^WIDTH-1)^3 fits; no wrap or saturation logic.

Reset
REQ-027 rst high at posedge: state IDLE, acc=0, cnt=0, out_valid=0, out_sum=0, out_count=0.
REQ-028 rst mid-frame or in HOLD SHALL discard the partial or pending result without emitting it.
REQ-029 rst SHALL have priority over accept, flush and out_ready in the same cycle.

Structure
REQ-030 Shared package mul_pkg SHALL hold the state typedef (IDLE/ACCUM/HOLD) and default WIDTH/COUNT constants.
REQ-031 No sub-module; accumulator, counter and FSM are local. Integration places multiplicacion directly upstream, its mul driving in_mul.

Verification (WIDTH=4, COUNT=5, SUM_W=15)
REQ-032 Products 1,2,3,4,5 back-to-back -> out_valid the cycle after the 5th accept, out_sum=15, out_count=5.
REQ-033 Five beats of 0xD2F (15*15*15) -> out_sum=0x41EB, out_count=5, no truncation.
REQ-034 Frame done, out_ready low 3 cycles with in_valid high -> out_valid held, out_sum stable, in_ready=0, no beat absorbed.
REQ-035 Beats 7, 9 with flush on the 9 beat -> out_sum=16, out_count=2.
REQ-036 rst after 3 accepted beats, then five beats of 1 -> no output before rst, then out_sum=5, out_count=5.
REQ-037 flush pulsed in IDLE with in_valid low -> out_valid stays 0, state IDLE.
